// File: rtl/duty_sel_ctrl.sv
// Debounced up/down push-button front end driving the 2-bit duty_sel code.
// Define DUTY_SEL_WRAP_EN for wrap-around stepping; the default build saturates at 00 and 11.
module duty_sel_ctrl #(
    parameter int          CLK_FREQ    = 100_000_000,
    parameter int          DEBOUNCE_MS = 10,
    parameter logic [1:0]  RESET_SEL   = 2'b01
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_up_n,
    input  logic       btn_down_n,
    output logic [1:0] duty_sel,
    output logic       duty_changed,
    output logic [1:0] btn_db
);

    localparam int DEBOUNCE_CYCLES = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Index 1 is the up button, index 0 the down button; all levels active-low.
    logic [1:0]       raw_n;
    logic [1:0]       s1;
    logic [1:0]       s2;
    logic [1:0]       stable;
    logic [CNT_W-1:0] cnt [2];
    logic [1:0]       press;
    logic [1:0]       sel_next;

    assign raw_n  = {btn_up_n, btn_down_n};
    assign btn_db = ~stable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1     <= 2'b11;
            s2     <= 2'b11;
            stable <= 2'b11;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            s1 <= raw_n;
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A press is the released-to-pressed commit happening on this very edge,
    // so duty_sel moves on the same edge as stable and btn_db.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            press[i] = stable[i] && !s2[i] && (cnt[i] == CNT_MAX);
        end
    end

    always_comb begin
        sel_next = duty_sel;
        if (press[1] && !press[0]) begin
`ifdef DUTY_SEL_WRAP_EN
            sel_next = duty_sel + 2'd1;
`else
            if (duty_sel != 2'b11) sel_next = duty_sel + 2'd1;
`endif
        end else if (press[0] && !press[1]) begin
`ifdef DUTY_SEL_WRAP_EN
            sel_next = duty_sel - 2'd1;
`else
            if (duty_sel != 2'b00) sel_next = duty_sel - 2'd1;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_sel     <= RESET_SEL;
            duty_changed <= 1'b0;
        end else begin
            duty_sel     <= sel_next;
            duty_changed <= (sel_next != duty_sel);
        end
    end

endmodule
